// File: rtl/pulse_peak_detector_pkg.sv
// Shared widths, FSM state encoding and event payload for the pulse peak detector.
package pulse_peak_detector_pkg;

  localparam int unsigned SIZE_SHAPER_DATA    = 16;
  localparam int unsigned SIZE_PEAK_TIMESTAMP = 32;
  localparam int unsigned SIZE_PEAK_WIDTH     = 10;
  localparam int unsigned SIZE_PEAK_HOLDOFF   = 8;
  localparam int unsigned SIZE_DROP_COUNT     = 8;

  typedef enum logic [1:0] {
    PD_IDLE    = 2'd0,
    PD_TRACK   = 2'd1,
    PD_HOLDOFF = 2'd2
  } peak_state_t;

  typedef struct packed {
    logic [SIZE_SHAPER_DATA-1:0]    amp;
    logic [SIZE_PEAK_TIMESTAMP-1:0] time_stamp;
    logic [SIZE_PEAK_WIDTH-1:0]     width;
    logic                           pile_up;
  } peak_event_t;

endpackage

// File: rtl/peak_event_slot.sv
// One-entry valid/ready holding register for pulse events, counting events lost while full.
module peak_event_slot
  import pulse_peak_detector_pkg::*;
#(
  parameter type event_t = peak_event_t
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_i,
  input  event_t                     event_i,
  input  logic                       ready_i,
  output logic                       valid_o,
  output event_t                     event_o,
  output logic [SIZE_DROP_COUNT-1:0] drop_count_o
);

  logic                       valid_q, valid_d;
  event_t                     event_q, event_d;
  logic [SIZE_DROP_COUNT-1:0] drop_q, drop_d;

  // A load is accepted when the slot is empty or is being drained this cycle.
  always_comb begin
    valid_d = valid_q;
    event_d = event_q;
    drop_d  = drop_q;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (load_i) begin
      if (!valid_q || ready_i) begin
        valid_d = 1'b1;
        event_d = event_i;
      end else if (drop_q != '1) begin
        drop_d = drop_q + SIZE_DROP_COUNT'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      event_q <= '0;
      drop_q  <= '0;
    end else begin
      valid_q <= valid_d;
      event_q <= event_d;
      drop_q  <= drop_d;
    end
  end

  assign valid_o      = valid_q;
  assign event_o      = event_q;
  assign drop_count_o = drop_q;

endmodule

// File: rtl/pulse_peak_detector.sv
// Threshold-crossing pulse detector: tracks each pulse's maximum, timestamp and width,
// and hands one event per pulse to the histogram stage over valid/ready.
module pulse_peak_detector
  import pulse_peak_detector_pkg::*;
#(
  parameter int unsigned DATA_W    = SIZE_SHAPER_DATA,
  parameter int unsigned TS_W      = SIZE_PEAK_TIMESTAMP,
  parameter int unsigned WIDTH_W   = SIZE_PEAK_WIDTH,
  parameter int unsigned HOLDOFF_W = SIZE_PEAK_HOLDOFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       data_valid,
  input  logic [DATA_W-1:0]          threshold,
  input  logic [WIDTH_W-1:0]         max_width,
  input  logic [HOLDOFF_W-1:0]       holdoff,
  input  logic                       out_ready,
  output logic                       peak_valid,
  output logic [DATA_W-1:0]          peak_amp,
  output logic [TS_W-1:0]            peak_time,
  output logic [WIDTH_W-1:0]         pulse_width,
  output logic                       pile_up,
  output logic [SIZE_DROP_COUNT-1:0] drop_count,
  output logic                       busy
);

  localparam logic [1:0] ST_IDLE    = 2'(PD_IDLE);
  localparam logic [1:0] ST_TRACK   = 2'(PD_TRACK);
  localparam logic [1:0] ST_HOLDOFF = 2'(PD_HOLDOFF);

  typedef struct packed {
    logic [DATA_W-1:0]  amp;
    logic [TS_W-1:0]    time_stamp;
    logic [WIDTH_W-1:0] width;
    logic               pile_up;
  } event_t;

  logic [1:0]           state_q, state_d;
  logic [TS_W-1:0]      ts_q, ts_d;
  logic [DATA_W-1:0]    peak_q, peak_d;
  logic [TS_W-1:0]      ptime_q, ptime_d;
  logic [WIDTH_W-1:0]   width_q, width_d;
  logic [HOLDOFF_W-1:0] hold_q, hold_d;
  logic                 emit_q, emit_d;
  event_t               evt_q, evt_d;
  logic                 busy_q, busy_d;

  logic                 above_c;
  logic                 term_c;
  logic                 pile_c;
  logic [WIDTH_W-1:0]   width_inc_c;
  event_t               slot_evt;

  assign above_c     = data_in > threshold;
  assign width_inc_c = (width_q == '1) ? width_q : width_q + WIDTH_W'(1);

  // Next-state logic; everything advances only on strobed samples.
  always_comb begin
    state_d = state_q;
    ts_d    = ts_q;
    peak_d  = peak_q;
    ptime_d = ptime_q;
    width_d = width_q;
    hold_d  = hold_q;
    emit_d  = 1'b0;
    evt_d   = evt_q;
    term_c  = 1'b0;
    pile_c  = 1'b0;

    if (data_valid) begin
      ts_d = ts_q + TS_W'(1);
      case (state_q)
        ST_IDLE: begin
          if (above_c) begin
            state_d = ST_TRACK;
            peak_d  = data_in;
            ptime_d = ts_q;
            width_d = WIDTH_W'(1);
            pile_c  = (max_width != '0) && (max_width == WIDTH_W'(1));
            term_c  = pile_c;
          end
        end
        ST_TRACK: begin
          if (above_c) begin
            if (data_in > peak_q) begin
              peak_d  = data_in;
              ptime_d = ts_q;
            end
            width_d = width_inc_c;
            pile_c  = (max_width != '0) && (width_inc_c == max_width);
            term_c  = pile_c;
          end else begin
            term_c = 1'b1;
          end
        end
        ST_HOLDOFF: begin
          if (hold_q <= HOLDOFF_W'(1)) begin
            state_d = ST_IDLE;
            hold_d  = '0;
          end else begin
            hold_d = hold_q - HOLDOFF_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // A zero holdoff skips the HOLDOFF state so the very next sample can retrigger.
      if (term_c) begin
        emit_d           = 1'b1;
        evt_d.amp        = peak_d;
        evt_d.time_stamp = ptime_d;
        evt_d.width      = width_d;
        evt_d.pile_up    = pile_c;
        hold_d           = holdoff;
        state_d          = (holdoff == '0) ? ST_IDLE : ST_HOLDOFF;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ts_q    <= '0;
      peak_q  <= '0;
      ptime_q <= '0;
      width_q <= '0;
      hold_q  <= '0;
      emit_q  <= 1'b0;
      evt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_d;
      peak_q  <= peak_d;
      ptime_q <= ptime_d;
      width_q <= width_d;
      hold_q  <= hold_d;
      emit_q  <= emit_d;
      evt_q   <= evt_d;
      busy_q  <= busy_d;
    end
  end

  peak_event_slot #(
    .event_t (event_t)
  ) u_slot (
    .clk          (clk),
    .reset        (reset),
    .load_i       (emit_q),
    .event_i      (evt_q),
    .ready_i      (out_ready),
    .valid_o      (peak_valid),
    .event_o      (slot_evt),
    .drop_count_o (drop_count)
  );

  assign peak_amp    = slot_evt.amp;
  assign peak_time   = slot_evt.time_stamp;
  assign pulse_width = slot_evt.width;
  assign pile_up     = slot_evt.pile_up;
  assign busy        = busy_q;

endmodule

// File: tb/tb_pulse_peak_detector.sv
// Bench for pulse_peak_detector: vector tables plus hand sequences, events checked via a scoreboard.
module tb_pulse_peak_detector;

  localparam int unsigned DW   = 16;
  localparam int unsigned TW   = 32;
  localparam int unsigned WW   = 10;
  localparam int unsigned HW   = 8;
  localparam int unsigned TW_S = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data_in;
  logic          data_valid;
  logic [DW-1:0] threshold;
  logic [WW-1:0] max_width;
  logic [HW-1:0] holdoff;
  logic          out_ready;

  logic          peak_valid, pile_up, busy;
  logic [DW-1:0] peak_amp;
  logic [TW-1:0] peak_time;
  logic [WW-1:0] pulse_width;
  logic [7:0]    drop_count;

  logic            s_peak_valid, s_pile_up, s_busy;
  logic [DW-1:0]   s_peak_amp;
  logic [TW_S-1:0] s_peak_time;
  logic [WW-1:0]   s_pulse_width;
  logic [7:0]      s_drop_count;

  typedef struct {
    logic [DW-1:0] amp;
    logic [TW-1:0] tim;
    logic [WW-1:0] wid;
    logic          pile;
  } exp_t;

  typedef struct {
    int unsigned thr;
    int unsigned maxw;
    int unsigned hold;
    bit          valid;
    int unsigned data;
    bit          emit;
    exp_t        ev;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  pulse_peak_detector dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .threshold(threshold), .max_width(max_width), .holdoff(holdoff), .out_ready(out_ready),
    .peak_valid(peak_valid), .peak_amp(peak_amp), .peak_time(peak_time),
    .pulse_width(pulse_width), .pile_up(pile_up), .drop_count(drop_count), .busy(busy)
  );

  pulse_peak_detector #(.TS_W(TW_S)) dut_ts4 (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .threshold(threshold), .max_width(max_width), .holdoff(holdoff), .out_ready(out_ready),
    .peak_valid(s_peak_valid), .peak_amp(s_peak_amp), .peak_time(s_peak_time),
    .pulse_width(s_pulse_width), .pile_up(s_pile_up), .drop_count(s_drop_count), .busy(s_busy)
  );

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pop and compare whenever the coming edge performs a transfer.
  task automatic sb_check();
    exp_t e;
    if (peak_valid && out_ready) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: event amp=%0d time=%0d with no expected entry", peak_amp, peak_time);
      end else begin
        e = sb_q.pop_front();
        chk("ev_amp",   64'(peak_amp),    64'(e.amp));
        chk("ev_time",  64'(peak_time),   64'(e.tim));
        chk("ev_width", 64'(pulse_width), 64'(e.wid));
        chk("ev_pile",  64'(pile_up),     64'(e.pile));
        chk("ev_ts4_time", 64'(s_peak_time), 64'(e.tim[TW_S-1:0]));
        chk("ev_ts4_amp",  64'(s_peak_amp),  64'(e.amp));
      end
    end
  endtask

  task automatic step(input int unsigned d, input bit v, input bit r);
    @(negedge clk);
    data_in    = DW'(d);
    data_valid = v;
    out_ready  = r;
    sb_check();
  endtask

  task automatic push_exp(input int unsigned amp, input int unsigned tim,
                          input int unsigned wid, input bit pile);
    exp_t e;
    e.amp  = DW'(amp);
    e.tim  = TW'(tim);
    e.wid  = WW'(wid);
    e.pile = pile;
    sb_q.push_back(e);
  endtask

  task automatic add_vec(input int unsigned thr, input int unsigned maxw, input int unsigned hold,
                         input bit valid, input int unsigned data, input bit emit,
                         input int unsigned amp, input int unsigned tim,
                         input int unsigned wid, input bit pile);
    vec_t v;
    v.thr = thr; v.maxw = maxw; v.hold = hold; v.valid = valid; v.data = data; v.emit = emit;
    v.ev.amp = DW'(amp); v.ev.tim = TW'(tim); v.ev.wid = WW'(wid); v.ev.pile = pile;
    vecs.push_back(v);
  endtask

  task automatic apply_vecs();
    foreach (vecs[i]) begin
      @(negedge clk);
      threshold = DW'(vecs[i].thr);
      max_width = WW'(vecs[i].maxw);
      holdoff   = HW'(vecs[i].hold);
      data_in    = DW'(vecs[i].data);
      data_valid = vecs[i].valid;
      out_ready  = 1'b1;
      sb_check();
      if (vecs[i].emit) sb_q.push_back(vecs[i].ev);
    end
    vecs.delete();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(peak_valid), 0);
    chk({tag, "_amp"},   64'(peak_amp), 0);
    chk({tag, "_time"},  64'(peak_time), 0);
    chk({tag, "_width"}, 64'(pulse_width), 0);
    chk({tag, "_pile"},  64'(pile_up), 0);
    chk({tag, "_drop"},  64'(drop_count), 0);
    chk({tag, "_busy"},  64'(busy), 0);
    chk({tag, "_ts4_or"}, 64'({s_peak_valid, s_peak_amp, s_peak_time, s_pulse_width,
                               s_pile_up, s_drop_count, s_busy} != '0), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b0;
    data_valid = 1'b0;
    out_ready  = 1'b0;
    repeat (3) @(negedge clk);
    sb_q.delete();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; data_in = '0; data_valid = 1'b0; out_ready = 1'b0;
    threshold = DW'(100); max_width = '0; holdoff = '0;

    // Reset held for 3 cycles
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    reset = 1'b1;

    // Single pulse with a tied maximum: earliest time kept, terminating sample not counted
    add_vec(100, 0, 0, 1,  50, 0,   0, 0, 0, 0);
    add_vec(100, 0, 0, 1, 120, 0,   0, 0, 0, 0);
    add_vec(100, 0, 0, 1, 300, 0,   0, 0, 0, 0);
    add_vec(100, 0, 0, 1, 300, 0,   0, 0, 0, 0);
    add_vec(100, 0, 0, 1, 200, 0,   0, 0, 0, 0);
    add_vec(100, 0, 0, 1,  90, 1, 300, 2, 4, 0);
    apply_vecs();
    step(0, 0, 1);
    chk("t2_valid_lat1", 64'(peak_valid), 0);
    step(0, 0, 1);
    chk("t2_valid_lat2", 64'(peak_valid), 1);
    step(0, 0, 1);
    chk("t2_valid_drop", 64'(peak_valid), 0);

    // Pile-up, holdoff skipping, gaps in data_valid, equality is not above threshold
    add_vec(100, 3, 2, 1, 500, 0,   0,  0, 0, 0);
    add_vec(100, 3, 2, 1, 500, 0,   0,  0, 0, 0);
    add_vec(100, 3, 2, 1, 500, 1, 500,  6, 3, 1);
    add_vec(100, 3, 2, 1, 500, 0,   0,  0, 0, 0);
    add_vec(100, 3, 2, 0, 999, 0,   0,  0, 0, 0);
    add_vec(100, 3, 2, 1, 500, 0,   0,  0, 0, 0);
    add_vec(100, 3, 2, 1, 500, 0,   0,  0, 0, 0);
    add_vec(100, 3, 2, 0, 999, 0,   0,  0, 0, 0);
    add_vec(100, 3, 2, 1, 700, 0,   0,  0, 0, 0);
    add_vec(100, 3, 2, 1,  50, 1, 700, 12, 2, 0);
    add_vec(100, 3, 2, 1, 800, 0,   0,  0, 0, 0);
    add_vec(100, 3, 2, 1, 800, 0,   0,  0, 0, 0);
    add_vec(100, 3, 2, 1, 100, 0,   0,  0, 0, 0);
    add_vec(100, 3, 2, 1, 101, 0,   0,  0, 0, 0);
    add_vec(100, 3, 2, 1, 100, 1, 101, 17, 1, 0);
    add_vec(100, 3, 2, 1,   0, 0,   0,  0, 0, 0);
    add_vec(100, 3, 2, 1,   0, 0,   0,  0, 0, 0);
    apply_vecs();
    repeat (3) step(0, 0, 1);
    chk("t3_idle_busy", 64'(busy), 0);

    // Backpressure: second event dropped, first held stable
    threshold = DW'(100); max_width = '0; holdoff = '0;
    step(200, 1, 0);
    step(150, 1, 0);
    step(10, 1, 0);
    push_exp(200, 21, 2, 0);
    step(300, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    chk("t4_held_amp_a", 64'(peak_amp), 200);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("t4_held_valid", 64'(peak_valid), 1);
    chk("t4_held_amp_b", 64'(peak_amp), 200);
    chk("t4_held_time",  64'(peak_time), 21);
    chk("t4_drop",       64'(drop_count), 1);
    step(0, 0, 1);
    step(0, 0, 0);
    chk("t4_valid_after", 64'(peak_valid), 0);
    chk("t4_drop_after",  64'(drop_count), 1);

    // Emit coinciding with a transfer
    do_reset();
    chk("t5_drop_reset", 64'(drop_count), 0);
    step(200, 1, 0);
    step(0, 1, 0);
    push_exp(200, 0, 1, 0);
    step(300, 1, 0);
    step(0, 1, 0);
    push_exp(300, 2, 1, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    chk("t5_valid_kept", 64'(peak_valid), 1);
    chk("t5_amp_b",      64'(peak_amp), 300);
    chk("t5_drop",       64'(drop_count), 0);
    step(0, 0, 1);
    step(0, 0, 0);
    chk("t5_valid_end", 64'(peak_valid), 0);

    // Timestamp wrap on the 4-bit instance, then reset in the middle of a pulse
    do_reset();
    threshold = DW'(100); max_width = '0; holdoff = '0;
    for (int i = 0; i < 20; i++) step(0, 1, 1);
    step(200, 1, 1);
    step(0, 1, 1);
    push_exp(200, 20, 1, 0);
    repeat (3) step(0, 0, 1);
    step(200, 1, 1);
    step(0, 0, 1);
    chk("t6_busy_track", 64'(busy), 1);
    reset = 1'b0;
    #1;
    chk("t6_busy_rst", 64'(busy), 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1);
      chk("t6_no_event", 64'(peak_valid), 0);
    end
    chk("t6_busy_after", 64'(busy), 0);

    chk("sb_drained", 64'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
